// File: rtl/id_stage_pkg.sv
// Shared widths, opcode/function encodings, bus payload structs and bypass helpers for the decode stage.
package id_stage_pkg;

  localparam int unsigned FS_TO_DS_BUS_WD = 64;
  localparam int unsigned DS_TO_ES_BUS_WD = 136;
  localparam int unsigned BR_BUS_WD       = 34;
  localparam int unsigned FWD_BUS_WD      = 39;
  localparam int unsigned WS_TO_RF_BUS_WD = 38;

  localparam int unsigned DATA_WD    = 32;
  localparam int unsigned REG_ADDR_WD = 5;
  localparam int unsigned REG_NUM    = 32;
  localparam int unsigned ALU_OP_WD  = 12;

  // alu_op bit positions, MSB (add) down to LSB (lui)
  localparam int unsigned ALU_ADD  = 11;
  localparam int unsigned ALU_SUB  = 10;
  localparam int unsigned ALU_SLT  = 9;
  localparam int unsigned ALU_SLTU = 8;
  localparam int unsigned ALU_AND  = 7;
  localparam int unsigned ALU_NOR  = 6;
  localparam int unsigned ALU_OR   = 5;
  localparam int unsigned ALU_XOR  = 4;
  localparam int unsigned ALU_SLL  = 3;
  localparam int unsigned ALU_SRL  = 2;
  localparam int unsigned ALU_SRA  = 1;
  localparam int unsigned ALU_LUI  = 0;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_ADDIU   = 6'h09,
    OP_LUI     = 6'h0f,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2b
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_SRA  = 6'h03,
    FN_JR   = 6'h08,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2a,
    FN_SLTU = 6'h2b
  } funct_e;

  typedef struct packed {
    logic [DATA_WD-1:0] inst;
    logic [DATA_WD-1:0] pc;
  } fs_to_ds_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_load;
    logic [REG_ADDR_WD-1:0] dest;
    logic [DATA_WD-1:0]     result;
  } fwd_t;

  typedef struct packed {
    logic                   we;
    logic [REG_ADDR_WD-1:0] waddr;
    logic [DATA_WD-1:0]     wdata;
  } ws_to_rf_t;

  typedef struct packed {
    logic               stall;
    logic               taken;
    logic [DATA_WD-1:0] target;
  } br_t;

  typedef struct packed {
    logic [ALU_OP_WD-1:0]   alu_op;
    logic                   load_op;
    logic                   src1_is_sa;
    logic                   src1_is_pc;
    logic                   src2_is_imm;
    logic                   src2_is_8;
    logic                   gr_we;
    logic                   mem_we;
    logic [REG_ADDR_WD-1:0] dest;
    logic [15:0]            imm;
    logic [DATA_WD-1:0]     rs_value;
    logic [DATA_WD-1:0]     rt_value;
    logic [DATA_WD-1:0]     pc;
  } ds_to_es_t;

  // A downstream stage supplies a source when it will write that (non-zero) register.
  function automatic logic fwd_hit(input fwd_t f, input logic [REG_ADDR_WD-1:0] src);
    return f.valid && (f.dest != REG_ADDR_WD'(0)) && (f.dest == src);
  endfunction

  function automatic logic ws_hit(input ws_to_rf_t w, input logic [REG_ADDR_WD-1:0] src);
    return w.we && (w.waddr != REG_ADDR_WD'(0)) && (w.waddr == src);
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port; $0 is hardwired to zero.
module id_stage_regfile
  import id_stage_pkg::*;
(
  input  logic                   clk,
  input  logic [REG_ADDR_WD-1:0] raddr1,
  output logic [DATA_WD-1:0]     rdata1,
  input  logic [REG_ADDR_WD-1:0] raddr2,
  output logic [DATA_WD-1:0]     rdata2,
  input  logic                   we,
  input  logic [REG_ADDR_WD-1:0] waddr,
  input  logic [DATA_WD-1:0]     wdata
);

  logic [DATA_WD-1:0] rf [REG_NUM];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we && (waddr != REG_ADDR_WD'(0))) begin
      rf[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == REG_ADDR_WD'(0)) ? DATA_WD'(0) : rf[raddr1];
  assign rdata2 = (raddr2 == REG_ADDR_WD'(0)) ? DATA_WD'(0) : rf[raddr2];

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: latches fetch bundle, decodes, reads/bypasses operands, detects hazards, resolves branches.
// Build option ID_FWD_EN: when defined, EX/MEM results are bypassed; otherwise ID interlocks on them.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_allowin,
  output logic                       ds_allowin,
  input  logic                       fs_to_ds_valid,
  input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       ds_to_es_valid,
  output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic [BR_BUS_WD-1:0]       br_bus,
  input  logic [FWD_BUS_WD-1:0]      es_fwd_bus,
  input  logic [FWD_BUS_WD-1:0]      ms_fwd_bus,
  input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus
);

  logic      ds_valid;
  logic      ds_ready_go;
  fs_to_ds_t fs_r;
  fwd_t      es_fwd;
  fwd_t      ms_fwd;
  ws_to_rf_t ws_wr;

  assign es_fwd = es_fwd_bus;
  assign ms_fwd = ms_fwd_bus;
  assign ws_wr  = ws_to_rf_bus;

  // Pipeline handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_r <= '0;
    end else if (fs_to_ds_valid && ds_allowin) begin
      fs_r <= fs_to_ds_bus;
    end
  end

  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ds_ready_go && !reset;

  // Instruction fields
  logic [5:0]             op;
  logic [5:0]             func;
  logic [REG_ADDR_WD-1:0] rs;
  logic [REG_ADDR_WD-1:0] rt;
  logic [REG_ADDR_WD-1:0] rd;
  logic [15:0]            imm;
  logic [25:0]            jidx;

  assign op   = fs_r.inst[31:26];
  assign rs   = fs_r.inst[25:21];
  assign rt   = fs_r.inst[20:16];
  assign rd   = fs_r.inst[15:11];
  assign imm  = fs_r.inst[15:0];
  assign jidx = fs_r.inst[25:0];
  assign func = fs_r.inst[5:0];

  logic op_special;
  logic inst_addu, inst_subu, inst_slt, inst_sltu, inst_and, inst_or, inst_xor, inst_nor;
  logic inst_sll, inst_srl, inst_sra, inst_jr;
  logic inst_addiu, inst_lui, inst_lw, inst_sw, inst_beq, inst_bne, inst_jal;

  assign op_special = (op == OP_SPECIAL);
  assign inst_addu  = op_special && (func == FN_ADDU);
  assign inst_subu  = op_special && (func == FN_SUBU);
  assign inst_slt   = op_special && (func == FN_SLT);
  assign inst_sltu  = op_special && (func == FN_SLTU);
  assign inst_and   = op_special && (func == FN_AND);
  assign inst_or    = op_special && (func == FN_OR);
  assign inst_xor   = op_special && (func == FN_XOR);
  assign inst_nor   = op_special && (func == FN_NOR);
  assign inst_sll   = op_special && (func == FN_SLL);
  assign inst_srl   = op_special && (func == FN_SRL);
  assign inst_sra   = op_special && (func == FN_SRA);
  assign inst_jr    = op_special && (func == FN_JR);
  assign inst_addiu = (op == OP_ADDIU);
  assign inst_lui   = (op == OP_LUI);
  assign inst_lw    = (op == OP_LW);
  assign inst_sw    = (op == OP_SW);
  assign inst_beq   = (op == OP_BEQ);
  assign inst_bne   = (op == OP_BNE);
  assign inst_jal   = (op == OP_JAL);

  logic rtype_alu;
  logic i_writer;
  logic is_branch;
  logic gr_we;
  logic use_rs;
  logic use_rt;

  assign rtype_alu = inst_addu | inst_subu | inst_slt | inst_sltu | inst_and | inst_or |
                     inst_xor | inst_nor | inst_sll | inst_srl | inst_sra;
  assign i_writer  = inst_addiu | inst_lui | inst_lw;
  assign is_branch = inst_beq | inst_bne | inst_jal | inst_jr;
  assign gr_we     = rtype_alu | i_writer | inst_jal;
  // Only sources the instruction actually consumes may cause a stall.
  assign use_rs    = inst_addu | inst_subu | inst_slt | inst_sltu | inst_and | inst_or |
                     inst_xor | inst_nor | inst_addiu | inst_lw | inst_sw |
                     inst_beq | inst_bne | inst_jr;
  assign use_rt    = rtype_alu | inst_sw | inst_beq | inst_bne;

  // Register file and operand bypass
  logic [DATA_WD-1:0] rf_rdata1;
  logic [DATA_WD-1:0] rf_rdata2;
  logic [DATA_WD-1:0] rs_value;
  logic [DATA_WD-1:0] rt_value;

  id_stage_regfile u_regfile (
    .clk    (clk),
    .raddr1 (rs),
    .rdata1 (rf_rdata1),
    .raddr2 (rt),
    .rdata2 (rf_rdata2),
    .we     (ws_wr.we),
    .waddr  (ws_wr.waddr),
    .wdata  (ws_wr.wdata)
  );

  logic es_rs_hit, ms_rs_hit, ws_rs_hit;
  logic es_rt_hit, ms_rt_hit, ws_rt_hit;
  logic unused_fwd_bits;

  assign es_rs_hit = fwd_hit(es_fwd, rs);
  assign ms_rs_hit = fwd_hit(ms_fwd, rs);
  assign ws_rs_hit = ws_hit(ws_wr, rs);
  assign es_rt_hit = fwd_hit(es_fwd, rt);
  assign ms_rt_hit = fwd_hit(ms_fwd, rt);
  assign ws_rt_hit = ws_hit(ws_wr, rt);

`ifdef ID_FWD_EN
  always_comb begin
    rs_value = rf_rdata1;
    if (es_rs_hit)      rs_value = es_fwd.result;
    else if (ms_rs_hit) rs_value = ms_fwd.result;
    else if (ws_rs_hit) rs_value = ws_wr.wdata;
  end

  always_comb begin
    rt_value = rf_rdata2;
    if (es_rt_hit)      rt_value = es_fwd.result;
    else if (ms_rt_hit) rt_value = ms_fwd.result;
    else if (ws_rt_hit) rt_value = ws_wr.wdata;
  end

  // A load in EX has no data yet; one bubble lets it reach MEM where it is forwardable.
  assign ds_ready_go = !(es_fwd.is_load && ((use_rs && es_rs_hit) || (use_rt && es_rt_hit)));
  assign unused_fwd_bits = ms_fwd.is_load;
`else
  assign rs_value = ws_rs_hit ? ws_wr.wdata : rf_rdata1;
  assign rt_value = ws_rt_hit ? ws_wr.wdata : rf_rdata2;

  // Without EX/MEM bypass, wait until the producer reaches WB.
  assign ds_ready_go = !((use_rs && (es_rs_hit || ms_rs_hit)) ||
                         (use_rt && (es_rt_hit || ms_rt_hit)));
  assign unused_fwd_bits = ^{es_fwd.is_load, ms_fwd.is_load, es_fwd.result, ms_fwd.result};
`endif

  // Decoded bundle to EX
  ds_to_es_t ds_bundle;

  always_comb begin
    ds_bundle                     = '0;
    ds_bundle.alu_op[ALU_ADD]     = inst_addu | inst_addiu | inst_lw | inst_sw | inst_jal;
    ds_bundle.alu_op[ALU_SUB]     = inst_subu;
    ds_bundle.alu_op[ALU_SLT]     = inst_slt;
    ds_bundle.alu_op[ALU_SLTU]    = inst_sltu;
    ds_bundle.alu_op[ALU_AND]     = inst_and;
    ds_bundle.alu_op[ALU_NOR]     = inst_nor;
    ds_bundle.alu_op[ALU_OR]      = inst_or;
    ds_bundle.alu_op[ALU_XOR]     = inst_xor;
    ds_bundle.alu_op[ALU_SLL]     = inst_sll;
    ds_bundle.alu_op[ALU_SRL]     = inst_srl;
    ds_bundle.alu_op[ALU_SRA]     = inst_sra;
    ds_bundle.alu_op[ALU_LUI]     = inst_lui;
    ds_bundle.load_op             = inst_lw;
    ds_bundle.src1_is_sa          = inst_sll | inst_srl | inst_sra;
    ds_bundle.src1_is_pc          = inst_jal;
    ds_bundle.src2_is_imm         = inst_addiu | inst_lui | inst_lw | inst_sw;
    ds_bundle.src2_is_8           = inst_jal;
    ds_bundle.gr_we               = gr_we;
    ds_bundle.mem_we              = inst_sw;
    if (gr_we) begin
      if (inst_jal)      ds_bundle.dest = REG_ADDR_WD'(31);
      else if (i_writer) ds_bundle.dest = rt;
      else               ds_bundle.dest = rd;
    end
    ds_bundle.imm                 = imm;
    ds_bundle.rs_value            = rs_value;
    ds_bundle.rt_value            = rt_value;
    ds_bundle.pc                  = fs_r.pc;
  end

  assign ds_to_es_bus = ds_bundle;

  // Branch resolution on bypassed operands
  logic               rs_eq_rt;
  logic               br_cond;
  logic [DATA_WD-1:0] br_target;
  br_t                br;

  assign rs_eq_rt = (rs_value == rt_value);
  assign br_cond  = (inst_beq && rs_eq_rt) || (inst_bne && !rs_eq_rt) || inst_jal || inst_jr;

  always_comb begin
    br_target = '0;
    if (inst_beq || inst_bne) begin
      br_target = fs_r.pc + DATA_WD'(4) + {{14{imm[15]}}, imm, 2'b00};
    end else if (inst_jal) begin
      br_target = {fs_r.pc[31:28], jidx, 2'b00};
    end else if (inst_jr) begin
      br_target = rs_value;
    end
  end

  always_comb begin
    br = '0;
    if (ds_valid && !reset) begin
      br.stall  = is_branch && !ds_ready_go;
      br.taken  = ds_ready_go && br_cond && es_allowin;
      br.target = br_target;
    end
  end

  assign br_bus = br;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; expectations follow ID_FWD_EN when the bundle is built with it.
module tb_id_stage;
  import id_stage_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       es_allowin;
  logic                       ds_allowin;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       ds_to_es_valid;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
  logic [BR_BUS_WD-1:0]       br_bus;
  fwd_t                       es_q;
  fwd_t                       ms_q;
  ws_to_rf_t                  ws_q;
  ds_to_es_t                  d;
  logic [31:0]                rf_m [32];
  int                         vectors = 0;
  int                         miscompares = 0;

  always #5 clk = ~clk;

  assign d = ds_to_es_bus;

  id_stage dut (
    .clk            (clk),
    .reset          (reset),
    .es_allowin     (es_allowin),
    .ds_allowin     (ds_allowin),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .br_bus         (br_bus),
    .es_fwd_bus     (es_q),
    .ms_fwd_bus     (ms_q),
    .ws_to_rf_bus   (ws_q)
  );

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; mirror any WB write into the reference register array.
  task automatic tick();
    @(posedge clk);
    if (ws_q.we && ws_q.waddr != 5'd0) rf_m[ws_q.waddr] = ws_q.wdata;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; es_allowin = 1'b1; fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0;
    es_q = '0; ms_q = '0; ws_q = '0;
    rf_m[0] = 32'h0;
    tick(); tick();
    @(negedge clk);
    chk("reset_valid",   136'(ds_to_es_valid), 136'(1'b0));
    chk("reset_br",      136'(br_bus),         136'(0));
    chk("reset_allowin", 136'(ds_allowin),     136'(1'b1));
    tick();
    reset = 1'b0;

    for (int i = 1; i < 32; i++) begin
      ws_q = {1'b1, 5'(i), 32'h1000_0000 + 32'(i)};
      tick();
    end
    ws_q = '0;

    // addiu $1,$0,5 then addu $2,$1,$1
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = {i_type(OP_ADDIU, 5'd0, 5'd1, 16'd5), 32'hbfc0_0000};
    tick();
    fs_to_ds_bus = {r_type(5'd1, 5'd1, 5'd2, FN_ADDU), 32'hbfc0_0004};
    @(negedge clk);
    chk("addiu_bus", ds_to_es_bus,
        {12'h800, 7'b0001010, 5'd1, 16'h0005, 32'h0, rf_m[1], 32'hbfc0_0000});
    chk("addiu_valid", 136'(ds_to_es_valid), 136'(1'b1));
    chk("addiu_br",    136'(br_bus),         136'(0));
    tick();
    fs_to_ds_valid = 1'b0;
    es_q = {1'b1, 1'b0, 5'd1, 32'd5};
    ms_q = {1'b1, 1'b0, 5'd1, 32'h77};
    ws_q = {1'b1, 5'd1, 32'h99};
    @(negedge clk);
`ifdef ID_FWD_EN
    chk("es_bypass_valid", 136'(ds_to_es_valid), 136'(1'b1));
    chk("es_bypass_rs",    136'(d.rs_value),     136'(32'd5));
    chk("es_bypass_rt",    136'(d.rt_value),     136'(32'd5));
    chk("es_bypass_dest",  136'(d.dest),         136'(5'd2));
    tick();
    es_q = '0; ms_q = '0; ws_q = {1'b1, 5'd1, 32'd5};
    tick();
    ws_q = '0;
`else
    chk("es_interlock_valid",   136'(ds_to_es_valid), 136'(1'b0));
    chk("es_interlock_allowin", 136'(ds_allowin),     136'(1'b0));
    tick();
    es_q = '0; ms_q = {1'b1, 1'b0, 5'd1, 32'd5}; ws_q = '0;
    @(negedge clk);
    chk("ms_interlock_valid", 136'(ds_to_es_valid), 136'(1'b0));
    tick();
    ms_q = '0; ws_q = {1'b1, 5'd1, 32'd5};
    @(negedge clk);
    chk("ws_release_valid", 136'(ds_to_es_valid), 136'(1'b1));
    chk("ws_release_rs",    136'(d.rs_value),     136'(32'd5));
    chk("ws_release_rt",    136'(d.rt_value),     136'(32'd5));
    tick();
    ws_q = '0;
`endif

    // lw $3 in EX, addu $4,$3,$0 in ID
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = {r_type(5'd3, 5'd0, 5'd4, FN_ADDU), 32'hbfc0_0008};
    tick();
    fs_to_ds_valid = 1'b0;
    es_q = {1'b1, 1'b1, 5'd3, 32'h0000_0040};
    @(negedge clk);
    chk("load_use_valid",   136'(ds_to_es_valid), 136'(1'b0));
    chk("load_use_allowin", 136'(ds_allowin),     136'(1'b0));
    tick();
    es_q = '0; ms_q = {1'b1, 1'b1, 5'd3, 32'h1234_5678}; ws_q = {1'b1, 5'd3, 32'h55};
    @(negedge clk);
`ifdef ID_FWD_EN
    chk("load_ms_valid", 136'(ds_to_es_valid), 136'(1'b1));
    chk("load_ms_rs",    136'(d.rs_value),     136'(32'h1234_5678));
    chk("load_ms_rt",    136'(d.rt_value),     136'(32'h0));
    tick();
    ms_q = '0; ws_q = {1'b1, 5'd3, 32'h1234_5678};
    tick();
    ws_q = '0;
`else
    chk("load_ms_interlock", 136'(ds_to_es_valid), 136'(1'b0));
    tick();
    ms_q = '0; ws_q = {1'b1, 5'd3, 32'h1234_5678};
    @(negedge clk);
    chk("load_ws_valid", 136'(ds_to_es_valid), 136'(1'b1));
    chk("load_ws_rs",    136'(d.rs_value),     136'(32'h1234_5678));
    tick();
    ws_q = '0;
`endif

    // beq taken, bne not taken, sw, unknown opcode, jal
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = {i_type(OP_BEQ, 5'd1, 5'd1, 16'h0003), 32'hbfc0_0010};
    tick();
    fs_to_ds_bus = {i_type(OP_BNE, 5'd1, 5'd1, 16'h0003), 32'hbfc0_0014};
    @(negedge clk);
    chk("beq_br",    136'(br_bus),         136'({2'b01, 32'hbfc0_0020}));
    chk("beq_valid", 136'(ds_to_es_valid), 136'(1'b1));
    tick();
    fs_to_ds_bus = {i_type(OP_SW, 5'd1, 5'd2, 16'h0010), 32'hbfc0_0018};
    @(negedge clk);
    chk("bne_br_flags", 136'(br_bus[33:32]), 136'(2'b00));
    tick();
    fs_to_ds_bus = {32'hfc00_0000, 32'hbfc0_001c};
    @(negedge clk);
    chk("sw_ctl",    136'({d.gr_we, d.mem_we, d.dest}), 136'({1'b0, 1'b1, 5'd0}));
    chk("sw_aluop",  136'(d.alu_op),                    136'(12'h800));
    tick();
    fs_to_ds_bus = {{6'h03, 26'h010_0040}, 32'hbfc0_0030};
    @(negedge clk);
    chk("unknown_ctl", 136'({d.gr_we, d.mem_we, d.dest}), 136'(0));
    tick();
    fs_to_ds_valid = 1'b0;
    @(negedge clk);
    chk("jal_br",  136'(br_bus), 136'({2'b01, 32'hb040_0100}));
    chk("jal_ctl", 136'({d.src1_is_pc, d.src2_is_8, d.gr_we, d.dest}),
        136'({1'b1, 1'b1, 1'b1, 5'd31}));

    // jr $31 behind a load of $31
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = {r_type(5'd31, 5'd0, 5'd0, FN_JR), 32'hbfc0_0040};
    tick();
    fs_to_ds_valid = 1'b0;
    es_q = {1'b1, 1'b1, 5'd31, 32'h0};
    @(negedge clk);
    chk("jr_stall",       136'(br_bus[33:32]),  136'(2'b10));
    chk("jr_stall_valid", 136'(ds_to_es_valid), 136'(1'b0));
    tick();
    es_q = '0; ms_q = {1'b1, 1'b1, 5'd31, 32'h8000_1234};
    @(negedge clk);
`ifdef ID_FWD_EN
    chk("jr_taken", 136'(br_bus), 136'({2'b01, 32'h8000_1234}));
    tick();
    ms_q = '0; ws_q = {1'b1, 5'd31, 32'h8000_1234};
    tick();
    ws_q = '0;
`else
    chk("jr_ms_stall", 136'(br_bus[33:32]), 136'(2'b10));
    tick();
    ms_q = '0; ws_q = {1'b1, 5'd31, 32'h8000_1234};
    @(negedge clk);
    chk("jr_taken", 136'(br_bus), 136'({2'b01, 32'h8000_1234}));
    tick();
    ws_q = '0;
`endif

    // WB write-through and $0
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = {r_type(5'd5, 5'd0, 5'd6, FN_ADDU), 32'hbfc0_0050};
    tick();
    fs_to_ds_bus = {r_type(5'd0, 5'd5, 5'd7, FN_ADDU), 32'hbfc0_0054};
    ws_q = {1'b1, 5'd5, 32'hdead_beef};
    @(negedge clk);
    chk("ws_same_cycle_rs", 136'(d.rs_value), 136'(32'hdead_beef));
    tick();
    ws_q = {1'b1, 5'd0, 32'hffff_ffff};
    fs_to_ds_bus = {r_type(5'd0, 5'd5, 5'd8, FN_OR), 32'hbfc0_0058};
    @(negedge clk);
    chk("zero_during_write_rs", 136'(d.rs_value), 136'(32'h0));
    chk("rf_written_rt",        136'(d.rt_value), 136'(32'hdead_beef));
    tick();
    ws_q = '0;
    fs_to_ds_valid = 1'b0;
    @(negedge clk);
    chk("zero_after_write_rs", 136'(d.rs_value), 136'(32'h0));
    chk("or_aluop_dest",       136'({d.alu_op, d.dest}), 136'({12'h020, 5'd8}));

    // EX back-pressure on a taken branch
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = {i_type(OP_BEQ, 5'd1, 5'd1, 16'h0003), 32'hbfc0_0060};
    tick();
    es_allowin = 1'b0;
    fs_to_ds_bus = {i_type(OP_ADDIU, 5'd0, 5'd9, 16'h0009), 32'hbfc0_0064};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_allowin",  136'(ds_allowin),     136'(1'b0));
      chk("hold_valid",    136'(ds_to_es_valid), 136'(1'b1));
      chk("hold_br_flags", 136'(br_bus[33:32]),  136'(2'b00));
      chk("hold_pc",       136'(d.pc),           136'(32'hbfc0_0060));
      tick();
    end
    es_allowin = 1'b1;
    @(negedge clk);
    chk("release_br",      136'(br_bus),     136'({2'b01, 32'hbfc0_0070}));
    chk("release_allowin", 136'(ds_allowin), 136'(1'b1));
    tick();
    fs_to_ds_valid = 1'b0;
    @(negedge clk);
    chk("next_bundle_pc",    136'(d.pc),           136'(32'hbfc0_0064));
    chk("next_bundle_valid", 136'(ds_to_es_valid), 136'(1'b1));

    // Reset mid-stream
    tick();
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = {i_type(OP_BEQ, 5'd1, 5'd1, 16'h0003), 32'hbfc0_0080};
    tick();
    @(negedge clk);
    chk("pre_reset_br", 136'(br_bus), 136'({2'b01, 32'hbfc0_0090}));
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_reset_valid", 136'(ds_to_es_valid), 136'(1'b0));
    chk("mid_reset_br",    136'(br_bus),         136'(0));
    reset = 1'b0;
    fs_to_ds_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("post_reset_valid", 136'(ds_to_es_valid), 136'(1'b0));
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = {r_type(5'd5, 5'd0, 5'd10, FN_ADDU), 32'hbfc0_0100};
    tick();
    fs_to_ds_valid = 1'b0;
    @(negedge clk);
    chk("rf_survives_reset", 136'(d.rs_value), 136'(32'hdead_beef));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
